// File: rtl/lbp_hist.sv
// 256-bin LBP-code histogram over interior pixels of one 128x128 frame, streamed out over valid/ready.
// Define LBP_HIST_UNIFORM_EN to fold non-uniform codes into one extra bin (index 256).
module lbp_hist #(
  parameter int IMG_W = 128,
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [8:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_last,
  output logic             hist_done
);

  typedef enum logic [1:0] {ACCUM, READOUT, DONE} state_e;

`ifdef LBP_HIST_UNIFORM_EN
  localparam logic [8:0] LAST_BIN = 9'd256;
`else
  localparam logic [8:0] LAST_BIN = 9'd255;
`endif
  localparam logic [6:0]       EDGE_HI = 7'(IMG_W - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [8:0]       bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q [256];
  logic [CNT_W-1:0] cnt_d [256];
`ifdef LBP_HIST_UNIFORM_EN
  logic [CNT_W-1:0] cnt_nu_q, cnt_nu_d;
`endif

  logic [6:0] px_x, px_y;
  logic       interior, sample_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

`ifdef LBP_HIST_UNIFORM_EN
  // Uniform codes have at most two 0/1 transitions around the circular bit ring.
  function automatic logic is_uniform(input logic [7:0] code);
    logic [7:0] edges;
    edges = code ^ {code[0], code[7:1]};
    return $countones(edges) <= 2;
  endfunction
`endif

  assign px_x       = lbp_addr[6:0];
  assign px_y       = lbp_addr[13:7];
  assign interior   = (px_x >= 7'd1) && (px_x <= EDGE_HI) &&
                      (px_y >= 7'd1) && (px_y <= EDGE_HI);
  assign sample_hit = lbp_valid && interior && (state_q == ACCUM);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
`ifdef LBP_HIST_UNIFORM_EN
    cnt_nu_d = cnt_nu_q;
`endif
    case (state_q)
      ACCUM: begin
        // Counters are flops updated in one cycle, so back-to-back equal codes cannot collide.
        if (sample_hit) begin
`ifdef LBP_HIST_UNIFORM_EN
          if (is_uniform(lbp_data)) cnt_d[lbp_data] = sat_inc(cnt_q[lbp_data]);
          else                      cnt_nu_d        = sat_inc(cnt_nu_q);
`else
          cnt_d[lbp_data] = sat_inc(cnt_q[lbp_data]);
`endif
        end
        if (finish) begin
          state_d = READOUT;
          bin_d   = 9'd0;
        end
      end
      READOUT: begin
        if (hist_ready) begin
          if (bin_q == LAST_BIN) state_d = DONE;
          else                   bin_d   = bin_q + 9'd1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: the counter array is held in flops with async reset because a reset must discard
  // partial counts immediately; a RAM could not clear 256 entries in zero cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
      bin_q   <= 9'd0;
      for (int i = 0; i < 256; i++) cnt_q[i] <= '0;
`ifdef LBP_HIST_UNIFORM_EN
      cnt_nu_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
`ifdef LBP_HIST_UNIFORM_EN
      cnt_nu_q <= cnt_nu_d;
`endif
    end
  end

  always_comb begin
    hist_valid = (state_q == READOUT);
    hist_last  = (state_q == READOUT) && (bin_q == LAST_BIN);
    hist_done  = (state_q == DONE);
    hist_bin   = bin_q;
    hist_count = '0;
    if (state_q == READOUT) begin
`ifdef LBP_HIST_UNIFORM_EN
      hist_count = bin_q[8] ? cnt_nu_q : cnt_q[bin_q[7:0]];
`else
      hist_count = cnt_q[bin_q[7:0]];
`endif
    end
  end

endmodule

// File: tb/tb_lbp_hist.sv
// Directed self-checking bench for lbp_hist: frame accumulation, stalled readout, mid-readout reset.
module tb_lbp_hist;

  localparam int CNT_W = 15;
`ifdef LBP_HIST_UNIFORM_EN
  localparam int NBEATS = 257;
  localparam bit UNI = 1'b1;
`else
  localparam int NBEATS = 256;
  localparam bit UNI = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             lbp_valid;
  logic [13:0]      lbp_addr;
  logic [7:0]       lbp_data;
  logic             finish;
  logic             hist_valid;
  logic             hist_ready;
  logic [8:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic             hist_last;
  logic             hist_done;

  lbp_hist #(.IMG_W(128), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .hist_last  (hist_last),
    .hist_done  (hist_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    bin;
    int    cnt;
  } exp_t;

  int checks   = 0;
  int failures = 0;
  int rx_cnt [NBEATS];
  int rx_n;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    lbp_valid  = 1'b0;
    lbp_addr   = '0;
    lbp_data   = '0;
    finish     = 1'b0;
    hist_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input int code, input bit fin);
    lbp_valid = 1'b1;
    lbp_addr  = {7'(y), 7'(x)};
    lbp_data  = 8'(code);
    finish    = fin;
    @(posedge clk);
    #1;
    lbp_valid = 1'b0;
  endtask

  // Drains the readout; ready follows 1,0,0,1 when toggle is set, else stays high.
  task automatic readout(input bit toggle);
    int        cyc, order_err, last_err, stall_err, stalls;
    bit        held;
    logic [8:0]       h_bin;
    logic [CNT_W-1:0] h_cnt;
    logic             h_last;
    bit        pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    cyc = 0; order_err = 0; last_err = 0; stall_err = 0; stalls = 0; held = 0;
    rx_n = 0;
    h_bin = '0; h_cnt = '0; h_last = 1'b0;
    for (int i = 0; i < NBEATS; i++) rx_cnt[i] = -1;
    while (rx_n < NBEATS && cyc < 4 * NBEATS + 50) begin
      hist_ready = toggle ? pat[cyc % 4] : 1'b1;
      if (held && (hist_bin != h_bin || hist_count != h_cnt || hist_last != h_last || !hist_valid))
        stall_err++;
      held = 0;
      if (hist_valid && hist_ready) begin
        if (int'(hist_bin) != rx_n) order_err++;
        if (hist_last != (rx_n == NBEATS - 1)) last_err++;
        rx_cnt[rx_n] = int'(hist_count);
        rx_n++;
      end else if (hist_valid) begin
        held = 1; stalls++;
        h_bin = hist_bin; h_cnt = hist_count; h_last = hist_last;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    hist_ready = 1'b0;
    check("beats_received", rx_n, NBEATS);
    check("bin_order_errors", order_err, 0);
    check("last_flag_errors", last_err, 0);
    check("stall_hold_errors", stall_err, 0);
    if (toggle) check("stalls_seen", int'(stalls > 0), 1);
    check("done_after_last", int'(hist_done), 1);
    check("valid_low_in_done", int'(hist_valid), 0);
    check("last_low_in_done", int'(hist_last), 0);
  endtask

  exp_t tbl [6];

  initial begin
    int nz;
    tbl[0] = '{"bin_A5_interior", 'hA5, UNI ? 0 : 1};
    tbl[1] = '{"bin_3C_border_finish", 'h3C, 0};
    tbl[2] = '{"bin_7F_back_to_back", 'h7F, 3};
    tbl[3] = '{"bin_00_unused", 'h00, 0};
    tbl[4] = '{"bin_FF_unused", 'hFF, 0};
    tbl[5] = '{"bin_last_uniform_nu", NBEATS - 1, UNI ? 1 : 0};

    // Reset state
    apply_reset();
    check("rst_valid", int'(hist_valid), 0);
    check("rst_bin",   int'(hist_bin),   0);
    check("rst_count", int'(hist_count), 0);
    check("rst_last",  int'(hist_last),  0);
    check("rst_done",  int'(hist_done),  0);

    // Frame 1: all-zero codes at every address
    for (int a = 0; a < 16384; a++) send(a % 128, a / 128, 0, 1'b0);
    check("accum_valid_low", int'(hist_valid), 0);
    finish = 1'b1;
    @(posedge clk);
    #1;
    check("f1_first_valid", int'(hist_valid), 1);
    readout(1'b0);
    check("f1_bin0", rx_cnt[0], 15876);
    nz = 0;
    for (int i = 1; i < NBEATS; i++) if (rx_cnt[i] != 0) nz++;
    check("f1_other_bins_nonzero", nz, 0);

    // Frame 2: interior/border/back-to-back/finish-same-cycle, stalled readout
    apply_reset();
    send(1, 1, 'hA5, 1'b0);
    send(0, 5, 'hA5, 1'b0);
    send(10, 20, 'h7F, 1'b0);
    send(11, 20, 'h7F, 1'b0);
    send(12, 20, 'h7F, 1'b0);
    check("f2_accum_valid_low", int'(hist_valid), 0);
    send(127, 127, 'h3C, 1'b1);
    check("f2_latency_valid", int'(hist_valid), 1);
    check("f2_latency_bin", int'(hist_bin), 0);
    check("f2_done_low_readout", int'(hist_done), 0);
    readout(1'b1);
    for (int i = 0; i < 6; i++) check(tbl[i].name, rx_cnt[tbl[i].bin], tbl[i].cnt);

    // Frame 3: reset during readout at bin 100, then a fresh frame
    apply_reset();
    send(3, 3, 'h40, 1'b0);
    send(4, 3, 'h40, 1'b0);
    finish = 1'b1;
    @(posedge clk);
    #1;
    hist_ready = 1'b1;
    for (int c = 0; c < 300 && hist_bin != 9'd100; c++) begin
      @(posedge clk);
      #1;
    end
    check("f3_reached_bin100", int'(hist_bin), 100);
    check("f3_bin100_valid", int'(hist_valid), 1);
    #2;
    reset  = 1'b0;
    finish = 1'b0;
    #1;
    check("midrst_valid", int'(hist_valid), 0);
    check("midrst_bin",   int'(hist_bin),   0);
    check("midrst_count", int'(hist_count), 0);
    check("midrst_last",  int'(hist_last),  0);
    check("midrst_done",  int'(hist_done),  0);
    hist_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(7, 9, 'h30, 1'b1);
    readout(1'b0);
    check("f3_new_bin30", rx_cnt['h30], 1);
    check("f3_old_bin40_cleared", rx_cnt['h40], 0);

`ifdef LBP_HIST_UNIFORM_EN
    // Frame 4: non-uniform codes fold into bin 256
    apply_reset();
    send(5, 5, 'h05, 1'b0);
    send(6, 5, 'h05, 1'b0);
    send(6, 6, 'h0F, 1'b0);
    finish = 1'b1;
    @(posedge clk);
    #1;
    readout(1'b0);
    check("u_bin05", rx_cnt[5], 0);
    check("u_bin0F", rx_cnt[15], 1);
    check("u_bin256_nu", rx_cnt[256], 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
